// File: rtl/rotreg_cmd_sequencer.sv
// Command sequencer for a WIDTH-bit rotating shift register: accepts LOAD/ROR/ROL/ASR commands
// and drives the register's per-cycle controls. Define ROTREG_SHADOW_EN to add the shadow_q register model.
module rotreg_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             reg_en,
    output logic             reg_load,
    output logic             reg_rotright,
    output logic             reg_asright,
    output logic [WIDTH-1:0] reg_data,
    output logic             busy,
    output logic             done
`ifdef ROTREG_SHADOW_EN
    ,
    output logic [WIDTH-1:0] shadow_q
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    state_t             state;
    state_t             state_next;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   remain_q;
    logic [WIDTH-1:0]   data_q;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command fields are captured only at the handshake; the counter then counts down one per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            remain_q <= '0;
            data_q   <= '0;
        end else if (accept) begin
            op_q     <= cmd_op;
            remain_q <= cmd_count;
            data_q   <= cmd_data;
        end else if (state == SHIFT) begin
            remain_q <= remain_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD) begin
                        state_next = LOAD;
                    end else if (cmd_count != '0) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LOAD:  state_next = DONE;
            SHIFT: begin
                if (remain_q == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs: direction/mode strobes are forced low whenever no step is issued.
    always_comb begin
        cmd_ready    = (state == IDLE);
        busy         = (state != IDLE);
        done         = (state == DONE);
        reg_en       = (state == LOAD) || (state == SHIFT);
        reg_load     = (state == LOAD);
        reg_rotright = (state == SHIFT) && (op_q != OP_ROL);
        reg_asright  = (state == SHIFT) && (op_q == OP_ASR);
        reg_data     = data_q;
    end

`ifdef ROTREG_SHADOW_EN
    function automatic logic [WIDTH-1:0] step_shadow(input logic [WIDTH-1:0] q,
                                                     input logic rotright,
                                                     input logic asright);
        if (!rotright) begin
            return {q[WIDTH-2:0], q[WIDTH-1]};
        end else if (asright) begin
            return {q[WIDTH-1], q[WIDTH-1:1]};
        end else begin
            return {q[0], q[WIDTH-1:1]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (reg_en) begin
            shadow_q <= reg_load ? reg_data : step_shadow(shadow_q, reg_rotright, reg_asright);
        end
    end
`endif

endmodule

// File: tb/tb_rotreg_cmd_sequencer.sv
// Scoreboard bench for rotreg_cmd_sequencer: stimulus pushes per-cycle expected outputs, a negedge monitor checks them.
module tb_rotreg_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_count = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       reg_en;
    logic       reg_load;
    logic       reg_rotright;
    logic       reg_asright;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;
`ifdef ROTREG_SHADOW_EN
    logic [7:0] shadow_q;
`endif

    rotreg_cmd_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .reg_en       (reg_en),
        .reg_load     (reg_load),
        .reg_rotright (reg_rotright),
        .reg_asright  (reg_asright),
        .reg_data     (reg_data),
        .busy         (busy),
        .done         (done)
`ifdef ROTREG_SHADOW_EN
        ,
        .shadow_q     (shadow_q)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [14:0] v;
        logic        chk_sh;
        logic [7:0]  sh;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;

    logic [14:0] act;
    assign act = {reg_en, reg_load, reg_rotright, reg_asright, done, busy, cmd_ready, reg_data};

    function automatic logic [14:0] pk(input bit en, input bit ld, input bit rr, input bit ar,
                                       input bit dn, input bit bz, input bit rd, input logic [7:0] d);
        return {en, ld, rr, ar, dn, bz, rd, d};
    endfunction

    task automatic push(input int c, input logic [14:0] v, input logic chk, input logic [7:0] sh);
        ev_t e;
        e.cyc = c;
        e.v = v;
        e.chk_sh = chk;
        e.sh = sh;
        sb.push_back(e);
    endtask

    // Monitor: {en,ld,rr,ar,done,busy,ready,data}
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d got=none required=%h", sb[0].cyc, sb[0].v);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                checks++;
                if (act !== mon_e.v) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h required=%h", cyc, act, mon_e.v);
                end
`ifdef ROTREG_SHADOW_EN
                if (mon_e.chk_sh) begin
                    checks++;
                    if (shadow_q !== mon_e.sh) begin
                        errors++;
                        $display("FAIL shadow cyc=%0d got=%h required=%h", cyc, shadow_q, mon_e.sh);
                    end
                end
`endif
            end else begin
                checks++;
                if (act[14:8] !== 7'b0000001) begin
                    errors++;
                    $display("FAIL idle cyc=%0d got=%b required=0000001", cyc, act[14:8]);
                end
            end
        end
    end

    task automatic handshake(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                             output int t, output bit ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout cyc=%0d got=ready_low required=ready_high", cyc);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                           input int hold, input logic [7:0] exp_sh);
        int t;
        bit ok;
        int n;
        bit rr;
        bit ar;
        handshake(op, cnt, data, t, ok);
        if (ok) begin
            n  = (op == 2'b00) ? 1 : int'(cnt);
            rr = (op == 2'b01) || (op == 2'b11);
            ar = (op == 2'b11);
            for (int i = 1; i <= n; i++) begin
                push(t + i, pk(1'b1, op == 2'b00, rr, ar, 1'b0, 1'b1, 1'b0, data), 1'b0, 8'h00);
            end
            push(t + n + 1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, data), 1'b1, exp_sh);
            push(t + n + 2, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, data), 1'b1, exp_sh);
            // Keep offering a different command while busy; it must be ignored.
            for (int k = 1; k <= hold; k++) begin
                @(negedge clk);
                cmd_op    = op ^ 2'b11;
                cmd_count = ~cnt;
                cmd_data  = ~data;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            while (cyc < t + n + 2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit ok;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(cyc + 1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00), 1'b1, 8'h00);
        mon_en = 1'b1;
        @(negedge clk);

        // Reset for two cycles in the middle of ROR 7
        run_cmd(2'b00, 4'd0, 8'h3C, 0, 8'h3C);
        handshake(2'b01, 4'd7, 8'h66, t, ok);
        if (ok) begin
            for (int i = 1; i <= 3; i++) begin
                push(t + i, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66), 1'b0, 8'h00);
            end
            push(t + 4, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00), 1'b1, 8'h00);
            push(t + 5, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00), 1'b1, 8'h00);
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
        end

        run_cmd(2'b00, 4'd0, 8'hA5, 0, 8'hA5);
        run_cmd(2'b01, 4'd1, 8'h00, 0, 8'hD2);
        run_cmd(2'b00, 4'd0, 8'h81, 0, 8'h81);
        run_cmd(2'b10, 4'd3, 8'h5A, 4, 8'h0C);
        run_cmd(2'b00, 4'd0, 8'h90, 0, 8'h90);
        run_cmd(2'b11, 4'd2, 8'h00, 0, 8'hE4);
        run_cmd(2'b01, 4'd0, 8'h00, 1, 8'hE4);
        run_cmd(2'b00, 4'd0, 8'h01, 0, 8'h01);
        run_cmd(2'b01, 4'd15, 8'h00, 0, 8'h02);
        run_cmd(2'b00, 4'd0, 8'h70, 0, 8'h70);
        run_cmd(2'b11, 4'd3, 8'h00, 0, 8'h0E);
        run_cmd(2'b10, 4'd1, 8'h00, 0, 8'h1C);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
